// File: rtl/adc_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_pack_pkg
//  Description : Shared constants and helpers for the ADC sample packer.
//                Holds the default configuration, the constants derived from
//                it (word width, slot index width, FIFO level width), the
//                drop counter width and the slot bit offset helper.
//  Optional    : none (ADC_PACK_FLUSH_EN only affects adc_sample_packer)
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_pack_pkg;

    localparam int DEF_SAMPLE_W         = 8;
    localparam int DEF_SLOT_W           = 8;
    localparam int DEF_SAMPLES_PER_WORD = 8;
    localparam int DEF_FIFO_DEPTH       = 4;

    // Derived constants for the default configuration. Parametrised
    // instances derive their own copies from their parameters.
    localparam int WORD_W = DEF_SLOT_W * DEF_SAMPLES_PER_WORD;
    localparam int IDX_W  = $clog2(DEF_SAMPLES_PER_WORD);
    localparam int LVL_W  = $clog2(DEF_FIFO_DEPTH + 1);

    localparam int DROP_CNT_W = 16;

    // Bit offset of slot k inside the packed word (slot 0 is the LSB slot).
    function automatic int slot_offset(input int k, input int slot_w);
        return k * slot_w;
    endfunction

endpackage : adc_pack_pkg
`default_nettype wire

// File: rtl/adc_sample_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_packer_if
//  Description : Downstream valid/ready word stream of the ADC sample packer.
//  Ports       : out_data  - packed word (head of the output buffer)
//                out_valid - out_data is valid
//                out_ready - downstream accepts the word
//  Modports    : master - packer side (drives data/valid, reads ready)
//                slave  - consumer side (reads data/valid, drives ready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_sample_packer_if
    import adc_pack_pkg::*;
#(
    parameter int DATA_W = WORD_W
);

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface : adc_sample_packer_if
`default_nettype wire

// File: rtl/adc_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : adc_word_fifo
//  Description : Small first-word-fall-through word buffer. The head entry is
//                presented combinationally on head_data (zero when empty).
//                A push into a full buffer is accepted only if a pop happens
//                in the same cycle; otherwise it is ignored and the caller
//                accounts for the drop.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                push, push_data    - write request and word
//                pop                - remove head (ignored when empty)
//                head_data          - current head word, 0 when empty
//                level, full, empty - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_word_fifo #(
    parameter  int WORD_W     = 64,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push,
    input  wire logic [WORD_W-1:0] push_data,
    input  wire logic              pop,
    output logic      [WORD_W-1:0] head_data,
    output logic      [LVL_W-1:0]  level,
    output logic                   full,
    output logic                   empty
);

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer frees its head slot in the same cycle when popped.
    assign do_push = push && (!full || do_pop);

    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage is not reset: contents are only visible through head_data,
    // which is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly PTR_W bits so they wrap on their own; full and
    // empty are told apart by level, not by pointer comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule : adc_word_fifo
`default_nettype wire

// File: rtl/adc_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_packer
//  Description : Collects SAMPLES_PER_WORD ADC samples into one wide word,
//                LSB slot first, each sample zero-extended to SLOT_W bits.
//                Finished words go into a first-word-fall-through buffer and
//                leave over a valid/ready stream. Words that find the buffer
//                full (with no simultaneous pop) are dropped and counted.
//  Ports       : adc_clk    - sole clock
//                rst        - synchronous active-high reset
//                adc_data   - ADC sample
//                adc_valid  - adc_data valid (no backpressure)
//                out_if     - packed word stream (out_data/out_valid/out_ready)
//                fifo_level - words currently buffered
//                overflow   - sticky, set when a word is dropped
//                drop_cnt   - dropped word count, saturating
//                flush      - push partial word (only with ADC_PACK_FLUSH_EN)
//  Optional    : `define ADC_PACK_FLUSH_EN adds the flush input.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_packer
    import adc_pack_pkg::*;
#(
    parameter  int SAMPLE_W         = DEF_SAMPLE_W,
    parameter  int SLOT_W           = DEF_SLOT_W,
    parameter  int SAMPLES_PER_WORD = DEF_SAMPLES_PER_WORD,
    parameter  int FIFO_DEPTH       = DEF_FIFO_DEPTH,
    localparam int WORD_BITS        = SLOT_W * SAMPLES_PER_WORD,
    localparam int IDX_BITS         = $clog2(SAMPLES_PER_WORD),
    localparam int LVL_BITS         = $clog2(FIFO_DEPTH + 1)
) (
    input  wire logic                  adc_clk,
    input  wire logic                  rst,
    input  wire logic [SAMPLE_W-1:0]   adc_data,
    input  wire logic                  adc_valid,
    adc_sample_packer_if.master        out_if,
    output logic      [LVL_BITS-1:0]   fifo_level,
    output logic                       overflow,
    output logic      [DROP_CNT_W-1:0] drop_cnt
`ifdef ADC_PACK_FLUSH_EN
    ,
    input  wire logic                  flush
`endif
);

    logic [IDX_BITS-1:0]  idx;
    logic [IDX_BITS-1:0]  idx_next;
    logic [WORD_BITS-1:0] asm_reg;
    logic [WORD_BITS-1:0] asm_next;
    logic [WORD_BITS-1:0] word_with_sample;
    logic                 last_sample;
    logic                 flush_push;
    logic                 push_req;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop;

    // Assembly register with the current sample (if any) merged into its
    // slot. This is both the next assembly value and the word to push, so a
    // completing or flushed word always includes the sample of that cycle.
    always_comb begin
        word_with_sample = asm_reg;
        if (adc_valid) begin
            word_with_sample[slot_offset(int'(idx), SLOT_W) +: SLOT_W] =
                SLOT_W'(adc_data);
        end
    end

    assign last_sample = adc_valid && (idx == IDX_BITS'(SAMPLES_PER_WORD - 1));

`ifdef ADC_PACK_FLUSH_EN
    // A flush with no collected and no arriving sample has nothing to send.
    assign flush_push = flush && ((idx != '0) || adc_valid);
`else
    assign flush_push = 1'b0;
`endif

    // A completing sample and a flush in the same cycle produce one push.
    assign push_req = last_sample || flush_push;

    always_comb begin
        idx_next = idx;
        asm_next = word_with_sample;
        if (push_req) begin
            idx_next = '0;
            asm_next = '0;
        end else if (adc_valid) begin
            idx_next = idx + 1'b1;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            idx     <= '0;
            asm_reg <= '0;
        end else begin
            idx     <= idx_next;
            asm_reg <= asm_next;
        end
    end

    assign pop  = out_if.out_valid && out_if.out_ready;
    assign drop = push_req && fifo_full && !pop;

    adc_word_fifo #(
        .WORD_W     (WORD_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (adc_clk),
        .rst        (rst),
        .push       (push_req),
        .push_data  (word_with_sample),
        .pop        (pop),
        .head_data  (out_if.out_data),
        .level      (fifo_level),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign out_if.out_valid = !fifo_empty;

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != {DROP_CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule : adc_sample_packer
`default_nettype wire

// File: doc/adc_sample_packer.md
Name: adc_sample_packer

Overview:
- Parametrised successor to the ADC word assembler. It collects SAMPLES_PER_WORD ADC samples into one wide word, filling slots LSB-first.
- Each sample is zero-extended into a SLOT_W-bit slot. This covers both 8-bit packed and 12-in-16 modes.
- Finished words are buffered in a small first-word-fall-through FIFO and handed downstream over a valid/ready handshake.
- Sits between the ADC capture register and the host-side transfer logic, in the adc_clk domain.

Parameters:
- SAMPLE_W, 8: ADC sample width in bits.
- SLOT_W, 8: slot width per sample. Must be >= SAMPLE_W; upper bits are zero-filled.
- SAMPLES_PER_WORD, 8: samples per output word. Must be >= 2.
- FIFO_DEPTH, 4: output word buffer depth. Must be a power of two, >= 2.

Ports:
- adc_clk, input, 1: sole clock.
- rst, input, 1: synchronous, active-high reset.
- adc_data, input, SAMPLE_W: ADC sample.
- adc_valid, input, 1: adc_data is valid this cycle. No backpressure to the ADC.
- out_data, output, SLOT_W*SAMPLES_PER_WORD: packed word.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts the word.
- fifo_level, output, $clog2(FIFO_DEPTH+1): number of words buffered.
- overflow, output, 1: sticky flag, set when a word is dropped.
- drop_cnt, output, 16: count of dropped words. Saturates at 0xFFFF.
- flush, input, 1: present only when ADC_PACK_FLUSH_EN is defined.

Behaviour:
- Reset (rst=1 at an adc_clk edge) clears the following; rst has priority over all other inputs:
  - slot index := 0
  - assembly register := 0
  - FIFO pointers := 0
  - out_valid=0, fifo_level=0, overflow=0, drop_cnt=0
  - out_data = 0
- Reset mid-word discards the partial word. Reset with words buffered discards them.
- Sample accept: when adc_valid=1, slot[idx] := zero_ext(adc_data), with slot k at bits [k*SLOT_W +: SLOT_W]. Then idx increments.
- Word completion: when idx = SAMPLES_PER_WORD-1 and adc_valid=1:
  - The word, including the current sample, is pushed to the FIFO.
  - idx := 0 and the assembly register clears in the same cycle.
  - Back-to-back words therefore need no idle cycle.
- Latency: the word appears with out_valid=1 on the cycle after its last sample is accepted, provided the FIFO was empty.
- Handshake:
  - A pop occurs on out_valid & out_ready.
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0.
  - out_valid is combinationally equal to (fifo_level != 0).
  - out_data equals the head entry. It is zero when the FIFO is empty.
- Full FIFO with a push:
  - If out_ready=1 and out_valid=1 in the same cycle, the pop and push both happen and the level is unchanged.
  - Otherwise the new word is dropped, overflow := 1, and drop_cnt increments (saturating).
- Empty FIFO: out_ready is ignored and no pointer moves.
- Simultaneous push and pop on a non-full FIFO: the level is unchanged.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full and empty are distinguished by fifo_level.
- adc_valid=0 holds all assembly state.

Optional Feature:
- Macro: ADC_PACK_FLUSH_EN.
- With the macro defined: the flush port exists. flush=1 with idx>0:
  - pushes the partial word with the unfilled slots zero;
  - sets idx := 0;
  - follows the same full/drop rules as a normal push.
- If flush and a sample arrive in the same cycle, the sample is included first. If it completes the word, only one push happens.
- flush with idx=0 and adc_valid=0 does nothing.
- Without the macro: no flush port. Partial words persist until completed or reset.

Decomposition:
- Package adc_pack_pkg holds:
  - the derived constants WORD_W = SLOT_W*SAMPLES_PER_WORD, IDX_W = $clog2(SAMPLES_PER_WORD), LVL_W = $clog2(FIFO_DEPTH+1);
  - DROP_CNT_W = 16;
  - a function for the slot offset.
- One sub-module: adc_word_fifo.
  - Parametrised on WORD_W and FIFO_DEPTH.
  - First-word-fall-through, with push/pop/level/full/empty.
  - The packer top holds the assembly register, slot index, and drop logic.

Test Plan:
- Defaults. Feed 0x01..0x08 with continuous adc_valid and out_ready=1. Expect out_valid for 1 cycle, one cycle after 0x08, with out_data=0x0807060504030201.
- SAMPLE_W=12, SLOT_W=16, SAMPLES_PER_WORD=4. Feed 0xABC, 0x123, 0xFFF, 0x001. Expect out_data=0x0001_0FFF_0123_0ABC, with upper nibbles zero.
- Defaults, out_ready=0, 40 samples. Expect fifo_level=4, overflow=1, drop_cnt=1, head word still 0x0807060504030201. Then assert out_ready: 4 words drain in order and fifo_level returns to 0.
- FIFO full with out_ready=1 in the same cycle as the 8th sample of a new word. Expect no drop, level stays 4, overflow stays 0.
- Assert rst after 5 samples, then feed 8 samples 0x10..0x17. Expect the single word 0x1716151413121110, with no residue from before the reset.
- ADC_PACK_FLUSH_EN defined. Feed 0xAA, 0xBB, then pulse flush. Expect out_data=0x000000000000BBAA. A second flush pulse does nothing.
